// File: rtl/iop_rst_pkg.sv
// Shared types and helpers for the IOP reset/clock-enable sequencer:
// FSM state encoding, reset levels and the per-core release threshold.
package iop_rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_SOFT = 2'd3
    } seq_state_e;

    localparam logic RST_LVL_L = 1'b0;  // level of every active-low output while in reset
    localparam logic RST_CKEN  = 1'b0;
    localparam logic RST_ACK   = 1'b0;
    localparam logic RST_BUSY  = 1'b1;

    // Release threshold of core idx: base delay plus its stagger slot.
    function automatic int unsigned core_thr(input int unsigned base,
                                             input int unsigned idx,
                                             input int unsigned stagger);
        return base + idx * stagger;
    endfunction

endpackage

// File: rtl/iop_rst_seq_if.sv
// Warm-reset handshake between the board/host side and iop_rst_seq.
// With IOP_RST_CNT_EN defined the interface also carries soft_rst_count.
interface iop_rst_seq_if #(
    parameter int unsigned NUM_CORES = 2
);
    logic                 soft_rst_req;
    logic [NUM_CORES-1:0] soft_rst_core;
    logic                 soft_rst_ack;
`ifdef IOP_RST_CNT_EN
    logic [15:0]          soft_rst_count;

    modport master (output soft_rst_req, output soft_rst_core,
                    input  soft_rst_ack, input  soft_rst_count);
    modport slave  (input  soft_rst_req, input  soft_rst_core,
                    output soft_rst_ack, output soft_rst_count);
`else
    modport master (output soft_rst_req, output soft_rst_core,
                    input  soft_rst_ack);
    modport slave  (input  soft_rst_req, input  soft_rst_core,
                    output soft_rst_ack);
`endif
endinterface

// File: rtl/iop_rst_sync.sv
// Two-flop synchroniser for the board reset; the output is 1 while the
// reset is asserted, whatever the input polarity.
module iop_rst_sync #(
    parameter int unsigned POL_HIGH = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_asserted
);
    logic w_asserted;
    logic r_meta;
    logic r_sync;

    assign w_asserted = (POL_HIGH != 0) ? i_async : ~i_async;

    // Flops come up asserted so the core stays in reset until the board reset is seen released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= w_asserted;
            r_sync <= r_meta;
        end
    end

    assign o_asserted = r_sync;
endmodule

// File: rtl/iop_rst_seq.sv
// Multi-core reset / clock-enable sequencer: ramps per-core releases at staggered
// thresholds and services warm-reset requests. Optional feature macro: IOP_RST_CNT_EN.
module iop_rst_seq
    import iop_rst_pkg::*;
#(
    parameter int unsigned NUM_CORES        = 2,
    parameter int unsigned C_EXT_RESET_HIGH = 0,
    parameter int unsigned CKEN_DLY         = 20,
    parameter int unsigned PRE_GRST_DLY     = 60,
    parameter int unsigned GRST_DLY         = 120,
    parameter int unsigned STAGGER          = 8,
    parameter int unsigned SOFT_HOLD        = 16,
    parameter int unsigned CNT_W            = 8
) (
    input  logic                 gclk,
    input  logic                 reset,
    input  logic                 ext_rst_in,
    input  logic [NUM_CORES-1:0] core_en_mask,
    iop_rst_seq_if.slave         sif,
    output logic [NUM_CORES-1:0] cmp_arst_l,
    output logic                 adbginit_l,
    output logic [NUM_CORES-1:0] cluster_cken,
    output logic [NUM_CORES-1:0] ctu_tst_pre_grst_l,
    output logic [NUM_CORES-1:0] cmp_grst_l,
    output logic [NUM_CORES-1:0] gdbginit_l,
    output logic                 seq_busy
);
    localparam int unsigned     HOLD_W   = $clog2(SOFT_HOLD + 1);
    localparam int unsigned     LAST_THR = core_thr(GRST_DLY, NUM_CORES - 1, STAGGER);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                 w_ext_rst;
    logic                 w_rst_int;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [NUM_CORES-1:0] w_en_nxt;
    logic [NUM_CORES-1:0] w_cken_cmp;
    logic [NUM_CORES-1:0] w_pre_cmp;
    logic [NUM_CORES-1:0] w_grst_cmp;
    logic [NUM_CORES-1:0] w_soft_m;
    logic                 w_ramp_done;
    logic                 w_ack_set;

    seq_state_e           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_CORES-1:0] r_en_q;
    logic [HOLD_W-1:0]    r_hold;
    logic [NUM_CORES-1:0] r_soft_m;
    logic [NUM_CORES-1:0] r_arst_l;
    logic                 r_adbg_l;
    logic [NUM_CORES-1:0] r_cken;
    logic [NUM_CORES-1:0] r_pre_l;
    logic [NUM_CORES-1:0] r_grst_l;
    logic [NUM_CORES-1:0] r_gdbg_l;
    logic                 r_ack;
    logic                 r_busy;

    iop_rst_sync #(
        .POL_HIGH   (C_EXT_RESET_HIGH)
    ) u_sync (
        .clk        (gclk),
        .reset      (reset),
        .i_async    (ext_rst_in),
        .o_asserted (w_ext_rst)
    );

    assign w_rst_int = reset | w_ext_rst;

    // Next ramp count and per-core threshold compares; outputs register these so they track the new count.
    always_comb begin
        w_en_nxt = (r_state == ST_HOLD) ? core_en_mask : r_en_q;
        if (r_state == ST_HOLD) begin
            w_cnt_nxt = CNT_W'(1);
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = CNT_MAX;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            w_cken_cmp[i] = w_en_nxt[i] & (w_cnt_nxt > CNT_W'(core_thr(CKEN_DLY, i, STAGGER)));
            w_pre_cmp[i]  = w_en_nxt[i] & (w_cnt_nxt > CNT_W'(core_thr(PRE_GRST_DLY, i, STAGGER)));
            w_grst_cmp[i] = w_en_nxt[i] & (w_cnt_nxt > CNT_W'(core_thr(GRST_DLY, i, STAGGER)));
        end
        w_ramp_done = (w_cnt_nxt > CNT_W'(LAST_THR));
        w_soft_m    = sif.soft_rst_core & r_en_q;
        w_ack_set   = ~w_rst_int &
                      (((r_state == ST_RUN) & sif.soft_rst_req & (w_soft_m == {NUM_CORES{1'b0}})) |
                       ((r_state == ST_SOFT) & (r_hold == HOLD_W'(1))));
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge gclk) begin
        if (w_rst_int) begin
            r_state  <= ST_HOLD;
            r_cnt    <= {CNT_W{1'b0}};
            r_en_q   <= {NUM_CORES{1'b0}};
            r_hold   <= {HOLD_W{1'b0}};
            r_soft_m <= {NUM_CORES{1'b0}};
            r_arst_l <= {NUM_CORES{RST_LVL_L}};
            r_adbg_l <= RST_LVL_L;
            r_cken   <= {NUM_CORES{RST_CKEN}};
            r_pre_l  <= {NUM_CORES{RST_LVL_L}};
            r_grst_l <= {NUM_CORES{RST_LVL_L}};
            r_gdbg_l <= {NUM_CORES{RST_LVL_L}};
            r_ack    <= RST_ACK;
            r_busy   <= RST_BUSY;
        end else begin
            r_ack <= w_ack_set;
            case (r_state)
                ST_HOLD, ST_RAMP: begin
                    r_en_q   <= w_en_nxt;
                    r_cnt    <= w_cnt_nxt;
                    r_arst_l <= w_en_nxt;
                    r_adbg_l <= 1'b1;
                    r_cken   <= w_cken_cmp;
                    r_pre_l  <= w_pre_cmp;
                    r_grst_l <= w_grst_cmp;
                    r_gdbg_l <= w_grst_cmp;
                    if (w_ramp_done) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_RAMP;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (sif.soft_rst_req && (w_soft_m != {NUM_CORES{1'b0}})) begin
                        r_state  <= ST_SOFT;
                        r_soft_m <= w_soft_m;
                        r_grst_l <= r_grst_l & ~w_soft_m;
                        r_gdbg_l <= r_gdbg_l & ~w_soft_m;
                        r_hold   <= HOLD_W'(SOFT_HOLD);
                        r_busy   <= 1'b1;
                    end
                end
                ST_SOFT: begin
                    if (r_hold == HOLD_W'(1)) begin
                        r_state  <= ST_RUN;
                        r_grst_l <= r_grst_l | r_soft_m;
                        r_gdbg_l <= r_gdbg_l | r_soft_m;
                        r_hold   <= {HOLD_W{1'b0}};
                        r_busy   <= 1'b0;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

`ifdef IOP_RST_CNT_EN
    logic [15:0] r_soft_cnt;

    // Saturating count of completed warm-reset handshakes, including empty-mask acks.
    always_ff @(posedge gclk) begin
        if (w_rst_int) begin
            r_soft_cnt <= 16'h0000;
        end else if (w_ack_set && (r_soft_cnt != 16'hffff)) begin
            r_soft_cnt <= r_soft_cnt + 16'h0001;
        end else begin
            r_soft_cnt <= r_soft_cnt;
        end
    end

    assign sif.soft_rst_count = r_soft_cnt;
`endif

    assign cmp_arst_l         = r_arst_l;
    assign adbginit_l         = r_adbg_l;
    assign cluster_cken       = r_cken;
    assign ctu_tst_pre_grst_l = r_pre_l;
    assign cmp_grst_l         = r_grst_l;
    assign gdbginit_l         = r_gdbg_l;
    assign sif.soft_rst_ack   = r_ack;
    assign seq_busy           = r_busy;
endmodule

// File: doc/iop_rst_seq.md
Name: iop_rst_seq

Overview:
Parametrised reset/clock-enable sequencer for multi-core IOP FPGA builds; successor to the single-core delay-counter sequencing in the current top-level wrapper. Synchronises an external reset into the gclk domain and releases cluster_cken, ctu_tst_pre_grst_l and cmp_grst_l/gdbginit_l per core at configurable thresholds, staggered per core. Adds a per-core warm (soft) reset handshake and a core enable mask. Sits between board reset logic and N sparc core instances.

Parameters:
NUM_CORES, 2, number of cores sequenced (1..8)
C_EXT_RESET_HIGH, 0, polarity of ext_rst_in (1 = active-high)
CKEN_DLY, 20, cluster_cken asserts when cnt > CKEN_DLY + i*STAGGER
PRE_GRST_DLY, 60, ctu_tst_pre_grst_l releases when cnt > PRE_GRST_DLY + i*STAGGER
GRST_DLY, 120, cmp_grst_l/gdbginit_l release when cnt > GRST_DLY + i*STAGGER
STAGGER, 8, per-core release offset in cycles
SOFT_HOLD, 16, cycles soft reset is held asserted (>=1)
CNT_W, 8, ramp counter width; must hold GRST_DLY+(NUM_CORES-1)*STAGGER+1

Ports:
gclk  in  1  core clock
reset  in  1  synchronous active-high reset
ext_rst_in  in  1  asynchronous board reset, polarity per C_EXT_RESET_HIGH
core_en_mask  in  NUM_CORES  1 = core sequenced; 0 = core held in reset
soft_rst_req  in  1  one-cycle warm reset request
soft_rst_core  in  NUM_CORES  cores targeted by soft_rst_req
cmp_arst_l  out  NUM_CORES  per-core arst, active-low
adbginit_l  out  1  global debug init, active-low
cluster_cken  out  NUM_CORES  per-core cluster clock enable
ctu_tst_pre_grst_l  out  NUM_CORES  per-core pre-grst, active-low
cmp_grst_l  out  NUM_CORES  per-core global reset, active-low
gdbginit_l  out  NUM_CORES  per-core debug init, active-low
soft_rst_ack  out  1  one-cycle pulse on soft reset completion
seq_busy  out  1  high unless FSM in RUN

Behaviour:
- ext_rst_in passes a 2-flop synchroniser; sync flops reset to asserted value. rst_int = reset | synchronised ext reset asserted.
- Reset values (rst_int=1): all active-low outputs 0, cluster_cken 0, soft_rst_ack 0, seq_busy 1, cnt 0, FSM HOLD.
- FSM states: HOLD, RAMP, RUN, SOFT.
- HOLD: on first edge with rst_int=0 -> RAMP; core_en_mask latched into en_q on that edge; cnt becomes 1; cmp_arst_l = en_q, adbginit_l = 1 from that edge.
- RAMP: cnt increments per edge, saturating at 2^CNT_W-1. Output k-th edge after release: cnt=k. Core i (en_q[i]=1) outputs are registered compares of next cnt: cluster_cken[i] high when k > CKEN_DLY+i*STAGGER, etc. Disabled cores: all outputs 0 permanently.
- RAMP -> RUN on edge where k > GRST_DLY+(NUM_CORES-1)*STAGGER; seq_busy drops that edge.
- RUN: soft_rst_req=1 -> m = soft_rst_core & en_q. m==0: soft_rst_ack pulses next edge, no state change. m!=0: -> SOFT; next edge cmp_grst_l[i]=gdbginit_l[i]=0 for i in m; cken, pre_grst, arst unchanged; hold counter loads SOFT_HOLD.
- SOFT: hold counter decrements; on reaching 0, targeted outputs return to 1 and soft_rst_ack pulses on that same edge; -> RUN. Asserted duration exactly SOFT_HOLD cycles.
- soft_rst_req in HOLD/RAMP/SOFT ignored, no ack. core_en_mask changes after HOLD ignored.
- rst_int mid-RAMP or mid-SOFT: synchronous return to reset values next edge; pending soft request dropped, no ack.
- Simultaneous reset and soft_rst_req: reset wins.

Optional Feature:
IOP_RST_CNT_EN: adds output soft_rst_count [15:0], incremented (saturating at 16'hffff) on each soft_rst_ack pulse including m==0 acks; cleared by rst_int. Without macro: port and counter absent.

Decomposition:
- Package iop_rst_pkg: FSM state encoding constants (HOLD/RAMP/RUN/SOFT), per-core threshold helper function (base + i*STAGGER), reset-value constants.
- Sub-module iop_rst_sync: 2-flop synchroniser with polarity parameter; instantiated once for ext_rst_in.

Test Plan:
- Defaults, reset 1 for 5 cycles then 0: core0 cken at edge 21, core1 at 29; pre_grst_l 61/69; grst_l 121/129; seq_busy 0 at edge 129.
- core_en_mask=2'b10: core0 outputs stay 0 throughout; core1 follows 29/69/129 timing; seq_busy drops at 129.
- In RUN, soft_rst_req with soft_rst_core=2'b01: core0 grst_l/gdbginit_l low for 16 cycles, ack pulse on release edge; core1 and all cken unchanged.
- soft_rst_req during RAMP and second request during SOFT: no ack, no output change beyond first request.
- ext_rst_in asserted (C_EXT_RESET_HIGH=0, drive 0) at RAMP edge 80: outputs reach reset values 3 edges later; re-release restarts timing from cnt=1.
- IOP_RST_CNT_EN defined: three soft requests (one with m==0) -> soft_rst_count=3; reset clears to 0.
